fcvt_s_w_seq: RTL
=================

# fcvt_s_w_seq

Sequential integer-to-single-precision converter for the FPU (FCVT.S.W / FCVT.S.WU). It accepts a 32-bit integer from the integer operand path over a valid/ready handshake. It normalises the integer with one left shift per cycle, rounds to nearest-even, and presents an IEEE-754 single-precision result for the FP register-file writeback path. That path is the source of operands for the float-to-integer converter.

## Interface
- No parameters. Bias 127 and width 32 are fixed.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  request present
- in_ready  output  1  converter idle and able to accept
- in_num  input  32  integer operand
- is_unsigned  input  1  1 = FCVT.S.WU (operand unsigned), 0 = signed two's complement
- flush  input  1  synchronous abort of any in-flight conversion
- out_valid  output  1  result present
- out_ready  input  1  consumer takes result
- out_num  output  32  single-precision result {sign, exp[7:0], mant[22:0]}
- out_inexact  output  1  NX flag for this result

## Operation
- States: IDLE, NORM, ROUND, DONE.
- in_ready = (state==IDLE). out_valid = (state==DONE).
- Accept occurs when in_valid && in_ready. At the accept edge the block registers:
  - sign = !is_unsigned & in_num[31]
  - mag = sign ? (~in_num+1) : in_num, 32-bit
  - exp = 8'd158 (127+31)
- If mag==0 at accept: out_num=32'h00000000, out_inexact=0, next state DONE. Zero is always +0.
- NORM:
  - If mag[31]==1, go to ROUND.
  - Else mag<=mag<<1 and exp<=exp-1, stay in NORM.
  - NORM lasts lz+1 cycles, where lz is the leading-zero count of mag.
- ROUND:
  - mant=mag[30:8], G=mag[7], S=|mag[6:0].
  - Round up when G && (S || mag[8]).
  - If the round-up carries out of mant (mant all ones), exp+1 and mant=0.
  - Register out_num={sign,exp,mant} and out_inexact=G|S, then go to DONE.
- DONE: hold out_num and out_inexact stable while out_ready=0. When out_ready=1, go to IDLE.
- Overflow cannot occur: the maximum exp is 159. NaN and infinity are never produced.
- INT_MIN signed (0x80000000): the negation yields 0x80000000, which is treated as magnitude 2^31 (correct).
- Inputs in_num and is_unsigned are sampled only at accept. Later changes have no effect.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_num=0, out_inexact=0. Internal mag and exp are cleared.
- Latency, with the accept cycle as c0:
  - Nonzero input: out_valid is first high in cycle c(lz+3). That is 3 cycles for lz=0 and 34 cycles for lz=31.
  - Zero input: out_valid is high in c1.
- No overlap: one conversion in flight. in_ready is low from c1 until the cycle after the out_valid && out_ready handshake.
- Back-to-back: a new accept can occur in the cycle after the output handshake (IDLE for at least 1 cycle).
- flush=1 in any state:
  - Next state is IDLE and out_valid is 0 the next cycle.
  - flush has priority over both accept and output handshake in the same cycle.
  - out_num keeps its last value; consumers qualify it with out_valid.
- rst mid-operation: all state is cleared asynchronously and the in-flight result is discarded.

## Test plan
- Signed in_num=32'h00000001 -> out_num=32'h3F800000, out_inexact=0, out_valid first high 34 cycles after accept.
- Signed 32'hFFFFFFFF -> 32'hBF800000. Signed 32'h80000000 -> 32'hCF000000 with latency 3. Signed 0 -> 32'h00000000 with latency 1.
- Unsigned 32'hFFFFFFFF -> 32'h4F800000 (round-carry into exponent), out_inexact=1.
- Round-to-nearest-even:
  - 32'h01000001 -> 32'h4B800000, NX=1 (tie, even, no increment).
  - 32'h01000003 -> 32'h4B800002, NX=1 (tie, odd, increment).
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_num and out_valid stable and in_ready=0. Raise out_ready -> IDLE next cycle, and the next accept succeeds.
- Abort:
  - Assert flush during NORM of 32'h00000001 -> out_valid never rises, in_ready=1 next cycle.
  - Assert rst mid-NORM -> all outputs return to their reset values immediately.

Source files
------------

// File: rtl/fcvt_s_w_seq.sv
// Sequential int32/uint32 to IEEE-754 single converter: one normalising shift per cycle, RNE rounding.
// Latency lz+3 cycles (1 for zero); one conversion in flight, result held in DONE until out_ready.
module fcvt_s_w_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_num,
    input  logic        is_unsigned,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_num,
    output logic        out_inexact
);

    typedef enum logic [1:0] {S_IDLE, S_NORM, S_ROUND, S_DONE} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_sign;
    logic [31:0] r_mag;
    logic [7:0]  r_exp;
    logic [31:0] r_out_num;
    logic        r_out_inexact;

    logic        w_accept;
    logic        w_sign;
    logic [31:0] w_mag;
    logic [22:0] w_mant;
    logic        w_g;
    logic        w_s;
    logic        w_rnd_up;
    logic [23:0] w_mant_sum;
    logic [7:0]  w_exp_rnd;

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = (r_state == S_DONE);
    assign out_num     = r_out_num;
    assign out_inexact = r_out_inexact;

    assign w_accept = in_valid && in_ready && !flush;
    assign w_sign   = !is_unsigned && in_num[31];
    // INT_MIN negates to itself, which reads correctly as magnitude 2^31.
    assign w_mag    = w_sign ? (~in_num + 32'd1) : in_num;

    assign w_mant     = r_mag[30:8];
    assign w_g        = r_mag[7];
    assign w_s        = |r_mag[6:0];
    assign w_rnd_up   = w_g && (w_s || r_mag[8]);
    assign w_mant_sum = {1'b0, w_mant} + {23'd0, w_rnd_up};
    assign w_exp_rnd  = r_exp + {7'd0, w_mant_sum[23]};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = (w_mag == 32'd0) ? S_DONE : S_NORM;
            S_NORM:  if (r_mag[31]) w_state_nxt = S_ROUND;
            S_ROUND: w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sign        <= 1'b0;
            r_mag         <= 32'd0;
            r_exp         <= 8'd0;
            r_out_num     <= 32'd0;
            r_out_inexact <= 1'b0;
        end else if (w_accept) begin
            r_sign <= w_sign;
            r_mag  <= w_mag;
            r_exp  <= 8'd158;
            if (w_mag == 32'd0) begin
                r_out_num     <= 32'd0;
                r_out_inexact <= 1'b0;
            end
        end else if (!flush && r_state == S_NORM && !r_mag[31]) begin
            r_mag <= r_mag << 1;
            r_exp <= r_exp - 8'd1;
        end else if (!flush && r_state == S_ROUND) begin
            // A mantissa carry-out leaves w_mant_sum[22:0] zero, as required.
            r_out_num     <= {r_sign, w_exp_rnd, w_mant_sum[22:0]};
            r_out_inexact <= w_g | w_s;
        end
    end

endmodule
